cache_mc_requester: RTL and testbench
=====================================

CACHE_MC_REQUESTER -- requirements
Module: cache_mc_requester

Interface
REQ-001 SHALL take parameters from Definitions.pkg: ADDRESSWIDTH, 32, request address width.
REQ-002 SHALL take DATAWIDTH, 512, line data width.
REQ-003 SHALL take TWIDTH, 3, read tag width (8 tags).
REQ-004 SHALL have port clock  in  1  single clock; all state on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have cache-side ports req_valid in 1, req_ready out 1, req_rw in 1 (1=read, 0=write), req_addr in ADDRESSWIDTH, req_data in DATAWIDTH.
REQ-007 SHALL have MC command ports cmd_valid out 1, cmd_ready in 1 (MC FIFO not full), cmd_rw out 1, cmd_addr out ADDRESSWIDTH, cmd_data out DATAWIDTH, cmd_tag out TWIDTH.
REQ-008 SHALL have MC read-return ports rd_valid in 1, rd_ready out 1, rd_data in DATAWIDTH, rd_tag in TWIDTH.
REQ-009 SHALL have cache response ports rsp_valid out 1, rsp_ready in 1, rsp_addr out ADDRESSWIDTH, rsp_data out DATAWIDTH.
REQ-010 SHALL have status ports outstanding out TWIDTH+1 (reads in flight) and tag_err out 1 (sticky).

Function
REQ-011 Handshake rule: a transfer occurs on any channel only when valid and ready are both high at a clock edge; valid, once high, SHALL hold with stable payload until accepted.
REQ-012 Issue FSM SHALL have states IDLE and ISSUE; IDLE->ISSUE on accepted request; ISSUE->IDLE on cmd_valid&&cmd_ready.
REQ-013 req_ready SHALL be high only in IDLE, and for reads only when at least one tag is free.
REQ-014 On request acceptance the request SHALL be registered; cmd_valid rises the next cycle (1-cycle latency).
REQ-015 Reads SHALL allocate the lowest-numbered free tag, mark it busy, and record req_addr in the tag table at acceptance.
REQ-016 Writes SHALL allocate no tag; cmd_tag SHALL be 0 for writes; cmd_data is don't-care for reads.
REQ-017 Read return SHALL be captured into a one-entry response register when rd_valid&&rd_ready; rsp_addr SHALL be the tag table address for rd_tag; the tag is freed in the same cycle.
REQ-018 rd_ready SHALL be high when the response register is empty, or when it is being drained this cycle (rsp_valid&&rsp_ready).
REQ-019 rsp_valid SHALL rise the cycle after capture and clear on rsp_ready unless a new capture occurs in the same cycle.
REQ-020 Return of a tag that is not busy SHALL be accepted and discarded (no rsp_valid) and SHALL set tag_err until reset.
REQ-021 outstanding SHALL equal the number of busy tags: +1 on read allocation, -1 on valid return, unchanged when both occur in the same cycle; range 0..8.
REQ-022 With 8 reads outstanding, a read request SHALL stall; a write request SHALL still be accepted.
REQ-023 A returning tag freed in cycle N SHALL NOT be reallocatable before cycle N+1.

Reset
REQ-024 Asserting reset SHALL immediately force: FSM=IDLE, all tags free, outstanding=0, tag_err=0, cmd_valid=0, rsp_valid=0, req_ready=0 while asserted, rd_ready=1 after release.
REQ-025 Reset mid-transaction SHALL drop in-flight commands and outstanding reads; returns after release for previously issued tags SHALL set tag_err.

Structure
REQ-026 ADDRESSWIDTH, DATAWIDTH and TWIDTH SHALL come from Definitions.pkg; the FSM state enum SHALL be placed in a shared package.
REQ-027 Tag bookkeeping (busy bits, address table, lowest-free encoder) SHALL be one sub-module, cache_tag_table.

Verification
REQ-028 Write at addr 0x0000_1040 with cmd_ready=1 -> cmd_valid the next cycle, cmd_rw=0, cmd_tag=0, outstanding stays 0.
REQ-029 Three reads back-to-back -> tags 0,1,2 issued; return tag 1 with data 0xA5.. -> rsp_addr equals the second request address; outstanding goes 3->2.
REQ-030 Eight reads with no returns -> 9th read stalls (req_ready=0) and a write is still accepted; one return -> the 9th read gets the freed tag.
REQ-031 cmd_ready held low for 5 cycles -> cmd_valid and payload held stable; issued on cycle 6.
REQ-032 rsp_ready=0 with two returns pending -> rd_ready=0 after the first capture; the second return is accepted in the same cycle rsp_ready rises.
REQ-033 Return of tag 5 with no tag busy -> no rsp_valid, tag_err=1; reset with 3 reads outstanding -> outstanding=0 and tag_err cleared.

Source files
------------

// File: rtl/cache_mc_requester_pkg.sv
// cache_mc_requester_pkg: shared types for the requester and its tag table.
package cache_mc_requester_pkg;

    import Definitions::*;

    // Issue FSM: IDLE accepts a cache request, ISSUE holds it until the MC takes it.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

    localparam int NTAGS = 1 << TWIDTH;

endpackage : cache_mc_requester_pkg

// File: rtl/definitions_pkg.sv
// Definitions: widths shared by the cache / memory-controller requester slice.
package Definitions;

    localparam int ADDRESSWIDTH = 32;   // request address width
    localparam int DATAWIDTH    = 512;  // cache line data width
    localparam int TWIDTH       = 3;    // read tag width (8 tags)

endpackage : Definitions

// File: rtl/cache_tag_table.sv
// cache_tag_table: busy bits, per-tag request address and lowest-free-tag encoder
// for reads in flight to the memory controller.
module cache_tag_table
    import Definitions::*;
    import cache_mc_requester_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,        // asynchronous, active-low
    input  logic                    alloc_en,     // allocate free_tag this cycle
    input  logic [ADDRESSWIDTH-1:0] alloc_addr,
    output logic                    any_free,
    output logic [TWIDTH-1:0]       free_tag,
    input  logic [TWIDTH-1:0]       lookup_tag,
    output logic                    lookup_busy,
    output logic [ADDRESSWIDTH-1:0] lookup_addr,
    input  logic                    release_en,   // free lookup_tag this cycle
    output logic [TWIDTH:0]         outstanding
);

    logic [NTAGS-1:0]        busy_q, busy_d;
    logic [ADDRESSWIDTH-1:0] addr_q [NTAGS];
    logic [ADDRESSWIDTH-1:0] addr_d [NTAGS];
    logic [TWIDTH:0]         count_q, count_d;

    // Lowest free tag from the registered busy bits, so a tag released this
    // cycle only becomes allocatable from the next cycle on.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free = 1'b1;
                free_tag = TWIDTH'(i);
            end
        end
    end

    assign lookup_busy = busy_q[lookup_tag];
    assign lookup_addr = addr_q[lookup_tag];
    assign outstanding = count_q;

    // Next busy bits, address table and in-flight count from allocate/release.
    always_comb begin
        busy_d  = busy_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (release_en) begin
            busy_d[lookup_tag] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[free_tag] = 1'b1;
            addr_d[free_tag] = alloc_addr;
        end
        case ({alloc_en, release_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tag state registers; reset frees every tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NTAGS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

endmodule : cache_tag_table

// File: rtl/cache_mc_requester.sv
// cache_mc_requester: forwards cache read/write requests to the memory
// controller command FIFO, tags reads, and returns read data with its address.
module cache_mc_requester
    import Definitions::*;
    import cache_mc_requester_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,        // asynchronous, active-low
    // cache request channel
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,       // 1 = read, 0 = write
    input  logic [ADDRESSWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0]    req_data,
    // MC command channel
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_rw,
    output logic [ADDRESSWIDTH-1:0] cmd_addr,
    output logic [DATAWIDTH-1:0]    cmd_data,
    output logic [TWIDTH-1:0]       cmd_tag,
    // MC read-return channel
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [DATAWIDTH-1:0]    rd_data,
    input  logic [TWIDTH-1:0]       rd_tag,
    // cache response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ADDRESSWIDTH-1:0] rsp_addr,
    output logic [DATAWIDTH-1:0]    rsp_data,
    // status
    output logic [TWIDTH:0]         outstanding,
    output logic                    tag_err
);

    issue_state_e            state_q, state_d;
    logic                    cmd_rw_q, cmd_rw_d;
    logic [ADDRESSWIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATAWIDTH-1:0]    cmd_data_q, cmd_data_d;
    logic [TWIDTH-1:0]       cmd_tag_q, cmd_tag_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [ADDRESSWIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATAWIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    tag_err_q, tag_err_d;

    logic                    any_free;
    logic [TWIDTH-1:0]       free_tag;
    logic                    lookup_busy;
    logic [ADDRESSWIDTH-1:0] lookup_addr;
    logic                    req_fire;
    logic                    rd_fire;
    logic                    rd_hit;

    // Reads need a free tag; nothing is accepted while reset is held.
    assign req_ready = reset && (state_q == IDLE) && (!req_rw || any_free);
    assign req_fire  = req_valid && req_ready;

    // Return path: room in the response register, or it is draining now.
    assign rd_ready  = !rsp_valid_q || rsp_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign rd_hit    = rd_fire && lookup_busy;

    cache_tag_table u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (req_fire && req_rw),
        .alloc_addr  (req_addr),
        .any_free    (any_free),
        .free_tag    (free_tag),
        .lookup_tag  (rd_tag),
        .lookup_busy (lookup_busy),
        .lookup_addr (lookup_addr),
        .release_en  (rd_hit),
        .outstanding (outstanding)
    );

    // Issue FSM: capture an accepted request, then hold it until the MC takes it.
    always_comb begin
        state_d    = state_q;
        cmd_rw_d   = cmd_rw_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_tag_d  = cmd_tag_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d    = ISSUE;
                    cmd_rw_d   = req_rw;
                    cmd_addr_d = req_addr;
                    cmd_data_d = req_data;
                    cmd_tag_d  = req_rw ? free_tag : '0;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response register: a hit loads it (even while draining), a stray tag is
    // swallowed and flagged sticky.
    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        tag_err_d   = tag_err_q;
        if (rd_hit) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = lookup_addr;
            rsp_data_d  = rd_data;
        end
        if (rd_fire && !lookup_busy) begin
            tag_err_d = 1'b1;
        end
    end

    // State, command and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_tag_q   <= cmd_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign cmd_valid = (state_q == ISSUE);
    assign cmd_rw    = cmd_rw_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_tag   = cmd_tag_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign tag_err   = tag_err_q;

endmodule : cache_mc_requester

// File: tb/tb_cache_mc_requester.sv
// tb_cache_mc_requester: directed, table-driven bench for cache_mc_requester.
module tb_cache_mc_requester;

    import Definitions::*;

    logic                    clock;
    logic                    reset;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDRESSWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0]    req_data;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rw;
    logic [ADDRESSWIDTH-1:0] cmd_addr;
    logic [DATAWIDTH-1:0]    cmd_data;
    logic [TWIDTH-1:0]       cmd_tag;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [DATAWIDTH-1:0]    rd_data;
    logic [TWIDTH-1:0]       rd_tag;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ADDRESSWIDTH-1:0] rsp_addr;
    logic [DATAWIDTH-1:0]    rsp_data;
    logic [TWIDTH:0]         outstanding;
    logic                    tag_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                    rw;
        logic [ADDRESSWIDTH-1:0] addr;
        logic [DATAWIDTH-1:0]    data;
        logic [TWIDTH-1:0]       exp_tag;
        logic [TWIDTH:0]         exp_out;
    } vec_t;

    vec_t vecs [5];

    cache_mc_requester dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_tag     (cmd_tag),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_tag      (rd_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .outstanding (outstanding),
        .tag_err     (tag_err)
    );

    // 100 MHz free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_tag    = '0;
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_tag_err", tag_err, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checkOutput("post_rst_rd_ready", rd_ready, 1);
        checkOutput("post_rst_req_ready", req_ready, 1);
    endtask

    // Present a request and wait (bounded) for it to be accepted.
    task automatic send_req(input logic rw, input logic [ADDRESSWIDTH-1:0] addr,
                            input logic [DATAWIDTH-1:0] data);
        logic accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_data  = data;
        for (int i = 0; i < 50 && !accepted; i++) begin
            #1;
            accepted = req_ready;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        checkOutput("req_accepted", accepted, 1);
    endtask

    // Check the pending command, then let the MC take it.
    task automatic issue_cmd(input logic rw, input logic [ADDRESSWIDTH-1:0] addr,
                             input logic [DATAWIDTH-1:0] data, input logic [TWIDTH-1:0] tag);
        checkOutput("cmd_valid", cmd_valid, 1);
        checkOutput("cmd_rw", cmd_rw, rw);
        checkOutput("cmd_addr", cmd_addr, addr);
        checkOutput("cmd_tag", cmd_tag, tag);
        if (!rw) begin
            checkOutput("cmd_data", cmd_data, data);
        end
        cmd_ready = 1'b1;
        @(posedge clock); #1;
        cmd_ready = 1'b0;
        checkOutput("cmd_valid_drop", cmd_valid, 0);
    endtask

    // Return one read (bounded wait on rd_ready).
    task automatic return_tag(input logic [TWIDTH-1:0] tag, input logic [DATAWIDTH-1:0] data);
        logic taken;
        taken    = 1'b0;
        rd_valid = 1'b1;
        rd_tag   = tag;
        rd_data  = data;
        for (int i = 0; i < 50 && !taken; i++) begin
            #1;
            taken = rd_ready;
            @(posedge clock); #1;
        end
        rd_valid = 1'b0;
        checkOutput("rd_accepted", taken, 1);
    endtask

    task automatic drain_rsp();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_drained", rsp_valid, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        send_req(v.rw, v.addr, v.data);
        issue_cmd(v.rw, v.addr, v.data, v.exp_tag);
        checkOutput("vec_outstanding", outstanding, v.exp_out);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1040, {16{32'h0123_4567}}, 3'd0, 4'd0};
        vecs[1] = '{1'b1, 32'h0000_2000, '0,                  3'd0, 4'd1};
        vecs[2] = '{1'b1, 32'h0000_2040, '0,                  3'd1, 4'd2};
        vecs[3] = '{1'b1, 32'h0000_2080, '0,                  3'd2, 4'd3};
        vecs[4] = '{1'b0, 32'h0000_3000, {16{32'hCAFE_F00D}}, 3'd0, 4'd3};

        do_reset();

        // Write then three reads then a write: tags 0,1,2 and write tag 0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Return tag 1: response carries the second read's address.
        rsp_ready = 1'b0;
        return_tag(3'd1, {64{8'hA5}});
        checkOutput("rsp_valid_t1", rsp_valid, 1);
        checkOutput("rsp_addr_t1", rsp_addr, 32'h0000_2040);
        checkOutput("rsp_data_t1", rsp_data, {64{8'hA5}});
        checkOutput("outstanding_3to2", outstanding, 2);
        drain_rsp();
        return_tag(3'd0, {64{8'h11}});
        drain_rsp();
        return_tag(3'd2, {64{8'h22}});
        checkOutput("rsp_addr_t2", rsp_addr, 32'h0000_2080);
        drain_rsp();
        checkOutput("outstanding_zero", outstanding, 0);
        checkOutput("no_tag_err", tag_err, 0);

        // Command back-pressure: payload held for 5 cycles, issued on the 6th.
        send_req(1'b0, 32'h0000_6000, {16{32'hDEAD_BEEF}});
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_cmd_valid", cmd_valid, 1);
            checkOutput("bp_cmd_addr", cmd_addr, 32'h0000_6000);
            checkOutput("bp_cmd_data", cmd_data, {16{32'hDEAD_BEEF}});
            checkOutput("bp_req_ready", req_ready, 0);
            @(posedge clock); #1;
        end
        issue_cmd(1'b0, 32'h0000_6000, {16{32'hDEAD_BEEF}}, 3'd0);

        // Eight reads fill every tag; reads stall, writes still pass.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_req(1'b1, 32'h0000_4000 + 32'(i * 64), '0);
            issue_cmd(1'b1, 32'h0000_4000 + 32'(i * 64), '0, 3'(i));
        end
        checkOutput("full_outstanding", outstanding, 8);
        req_rw = 1'b1;
        #1;
        checkOutput("full_read_stall", req_ready, 0);
        send_req(1'b0, 32'h0000_7000, {16{32'h5555_AAAA}});
        issue_cmd(1'b0, 32'h0000_7000, {16{32'h5555_AAAA}}, 3'd0);
        checkOutput("full_write_outstanding", outstanding, 8);
        // 9th read waits; tag 5 returns; the freed tag is not usable that cycle.
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 32'h0000_8000;
        rd_valid  = 1'b1;
        rd_tag    = 3'd5;
        rd_data   = {64{8'h5A}};
        #1;
        checkOutput("ninth_stall", req_ready, 0);
        @(posedge clock); #1;
        rd_valid = 1'b0;
        checkOutput("ninth_ready_after_free", req_ready, 1);
        checkOutput("rsp_addr_t5", rsp_addr, 32'h0000_4140);
        checkOutput("outstanding_7", outstanding, 7);
        send_req(1'b1, 32'h0000_8000, '0);
        issue_cmd(1'b1, 32'h0000_8000, '0, 3'd5);
        checkOutput("outstanding_8_again", outstanding, 8);
        drain_rsp();

        // Response back-pressure with two returns pending.
        do_reset();
        send_req(1'b1, 32'h0000_5000, '0);
        issue_cmd(1'b1, 32'h0000_5000, '0, 3'd0);
        send_req(1'b1, 32'h0000_5040, '0);
        issue_cmd(1'b1, 32'h0000_5040, '0, 3'd1);
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_tag    = 3'd0;
        rd_data   = {64{8'hD0}};
        #1;
        checkOutput("bp_rd_ready_empty", rd_ready, 1);
        @(posedge clock); #1;
        rd_tag  = 3'd1;
        rd_data = {64{8'hD1}};
        checkOutput("bp_rsp_valid", rsp_valid, 1);
        checkOutput("bp_rd_ready_full", rd_ready, 0);
        @(posedge clock); #1;
        checkOutput("bp_rd_ready_held", rd_ready, 0);
        checkOutput("bp_rsp_addr_held", rsp_addr, 32'h0000_5000);
        checkOutput("bp_outstanding_1", outstanding, 1);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_rd_ready_drain", rd_ready, 1);
        @(posedge clock); #1;
        rd_valid = 1'b0;
        checkOutput("bp_rsp_valid_reload", rsp_valid, 1);
        checkOutput("bp_rsp_addr_second", rsp_addr, 32'h0000_5040);
        checkOutput("bp_rsp_data_second", rsp_data, {64{8'hD1}});
        checkOutput("bp_outstanding_0", outstanding, 0);
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        checkOutput("bp_rsp_valid_clear", rsp_valid, 0);

        // Stray tag return, then reset with reads in flight.
        do_reset();
        return_tag(3'd5, {64{8'hEE}});
        checkOutput("stray_rsp_valid", rsp_valid, 0);
        checkOutput("stray_tag_err", tag_err, 1);
        checkOutput("stray_outstanding", outstanding, 0);
        send_req(1'b1, 32'h0000_9000, '0);
        issue_cmd(1'b1, 32'h0000_9000, '0, 3'd0);
        send_req(1'b1, 32'h0000_9040, '0);
        issue_cmd(1'b1, 32'h0000_9040, '0, 3'd1);
        send_req(1'b1, 32'h0000_9080, '0);
        checkOutput("mid_outstanding_3", outstanding, 3);
        checkOutput("mid_cmd_pending", cmd_valid, 1);
        checkOutput("mid_tag_err_sticky", tag_err, 1);
        reset = 1'b0;
        #1;
        checkOutput("async_outstanding", outstanding, 0);
        checkOutput("async_tag_err", tag_err, 0);
        checkOutput("async_cmd_valid", cmd_valid, 0);
        checkOutput("async_req_ready", req_ready, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        return_tag(3'd0, {64{8'h77}});
        checkOutput("old_tag_rsp_valid", rsp_valid, 0);
        checkOutput("old_tag_err", tag_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cache_mc_requester
